// File: rtl/aes_pkg.sv
// Shared AES types and helpers: cipher direction, MixColumns sequencer states,
// column slicing of a 128-bit state and GF(2^8) doubling.
package aes_pkg;

  typedef enum logic {
    CIPH_FWD = 1'b0,
    CIPH_INV = 1'b1
  } ciph_op_e;

  typedef enum logic [1:0] {
    MIX_IDLE = 2'd0,
    MIX_BUSY = 2'd1,
    MIX_DONE = 2'd2
  } mix_seq_state_e;

  function automatic logic [31:0] aes_col_get(input logic [127:0] state, input logic [1:0] idx);
    return state[{idx, 5'b00000} +: 32];
  endfunction

  function automatic logic [127:0] aes_col_set(input logic [127:0] state, input logic [1:0] idx,
                                               input logic [31:0] col);
    logic [127:0] s;
    s = state;
    s[{idx, 5'b00000} +: 32] = col;
    return s;
  endfunction

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] aes_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_mix_single_column.sv
// MixColumns / InvMixColumns on one 32-bit column (byte r at bits [8r+7:8r]).
module aes_mix_single_column
  import aes_pkg::*;
(
  input  logic        i_mode,
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);

  logic [7:0] w_a [4];
  logic [7:0] w_u [4];
  logic [7:0] w_x02;
  logic [7:0] w_x13;
  logic [7:0] w_sum;

  // Inverse = forward matrix applied after a cheap {5,0,4,0} circulant pre-step.
  assign w_x02 = (i_mode == CIPH_INV) ? aes_xtime(aes_xtime(w_a[0] ^ w_a[2])) : 8'h00;
  assign w_x13 = (i_mode == CIPH_INV) ? aes_xtime(aes_xtime(w_a[1] ^ w_a[3])) : 8'h00;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign w_a[gi] = i_col[8*gi +: 8];
      assign w_u[gi] = w_a[gi] ^ (((gi % 2) == 0) ? w_x02 : w_x13);
      assign o_col[8*gi +: 8] = w_u[gi] ^ w_sum ^ aes_xtime(w_u[gi] ^ w_u[(gi + 1) % 4]);
    end
  endgenerate

  assign w_sum = w_u[0] ^ w_u[1] ^ w_u[2] ^ w_u[3];

endmodule

// File: rtl/aes_mix_columns_seq.sv
// Time-multiplexed MixColumns: one group of ColsPerCycle columns per cycle,
// valid/ready on both sides, result visible only while out_valid_o is high.
module aes_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int ColsPerCycle = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         mode_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] data_o,
  output logic         busy_o
);

  localparam int         NumGroups = 4 / ColsPerCycle;
  localparam logic [1:0] LastCnt   = 2'(NumGroups - 1);

  generate
    if (!(ColsPerCycle == 1 || ColsPerCycle == 2 || ColsPerCycle == 4)) begin : g_bad_cpc
      $error("aes_mix_columns_seq: ColsPerCycle must be 1, 2 or 4");
    end
  endgenerate

  mix_seq_state_e r_fsm;
  logic [127:0]   r_state;
  ciph_op_e       r_mode;
  logic [1:0]     r_col_cnt;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_busy;

  logic [1:0]     w_col_idx [ColsPerCycle];
  logic [31:0]    w_col_in  [ColsPerCycle];
  logic [31:0]    w_col_out [ColsPerCycle];
  logic [127:0]   w_state_mixed;
  logic [1:0]     w_col_cnt_next;

  genvar gi;
  generate
    for (gi = 0; gi < ColsPerCycle; gi++) begin : g_col
      assign w_col_idx[gi] = 2'(int'(r_col_cnt) * ColsPerCycle + gi);
      assign w_col_in[gi]  = aes_col_get(r_state, w_col_idx[gi]);

      aes_mix_single_column u_col (
        .i_mode (r_mode),
        .i_col  (w_col_in[gi]),
        .o_col  (w_col_out[gi])
      );
    end
  endgenerate

  always_comb begin
    w_state_mixed = r_state;
    for (int i = 0; i < ColsPerCycle; i++) begin
      w_state_mixed = aes_col_set(w_state_mixed, w_col_idx[i], w_col_out[i]);
    end
  end

  // Counter bits above the group range never become set.
  assign w_col_cnt_next = (r_col_cnt == LastCnt) ? 2'd0 : r_col_cnt + 2'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_fsm       <= MIX_IDLE;
      r_state     <= '0;
      r_mode      <= CIPH_FWD;
      r_col_cnt   <= 2'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_fsm)
        MIX_IDLE: begin
          if (in_valid_i) begin
            r_fsm      <= MIX_BUSY;
            r_state    <= data_i;
            r_mode     <= ciph_op_e'(mode_i);
            r_col_cnt  <= 2'd0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        MIX_BUSY: begin
          r_state   <= w_state_mixed;
          r_col_cnt <= w_col_cnt_next;
          if (r_col_cnt == LastCnt) begin
            r_fsm       <= MIX_DONE;
            r_out_valid <= 1'b1;
          end
        end
        MIX_DONE: begin
          if (out_ready_i) begin
            r_fsm       <= MIX_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_fsm       <= MIX_IDLE;
          r_state     <= '0;
          r_mode      <= CIPH_FWD;
          r_col_cnt   <= 2'd0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign busy_o      = r_busy;
  assign data_o      = r_out_valid ? r_state : 128'h0;

endmodule
